// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern/length and overlap mode.
// One shift-register history drives both a same-cycle (Mealy) and a registered (Moore) match flag.
module seq_detect_param #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             mealy_flag,
  output logic             moore_flag,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PAT_W-1:0] pat_reg;
  logic [LEN_W-1:0] len_reg;
  logic             ovl_reg;
  logic [PAT_W-1:0] hist_reg;
  logic [LEN_W-1:0] fill_reg;
  logic             moore_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [LEN_W-1:0] len_next;
  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] mask;
  logic             enough;
  logic             match;

  // Clamp the requested length into 1..PAT_W before it is stored.
  always_comb begin
    len_next = cfg_len;
    if (cfg_len == '0)
      len_next = LEN_W'(1);
    else if (cfg_len > LEN_MAX)
      len_next = LEN_MAX;
  end

  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
      localparam logic [LEN_W:0] BIT_IDX = (LEN_W+1)'(gi);
      assign mask[gi] = BIT_IDX < {1'b0, len_reg};
    end
  endgenerate

  assign cand   = {hist_reg[PAT_W-2:0], din};
  assign enough = ({1'b0, fill_reg} + (LEN_W+1)'(1)) >= {1'b0, len_reg};
  assign match  = ~rst & din_vld & ~cfg_load & enough & (((cand ^ pat_reg) & mask) == '0);

  assign mealy_flag = match;
  assign moore_flag = moore_reg;
  assign match_cnt  = cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_reg <= '0;
      len_reg <= LEN_MAX;
      ovl_reg <= 1'b1;
    end else if (cfg_load) begin
      pat_reg <= cfg_pattern;
      len_reg <= len_next;
      ovl_reg <= cfg_overlap;
    end
  end

  // A non-overlapping match wipes history so the completing bit cannot be reused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (cfg_load || (match && !ovl_reg)) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (din_vld) begin
      hist_reg <= cand;
      if (fill_reg != LEN_MAX)
        fill_reg <= fill_reg + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      moore_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      moore_reg <= match;
      if (cnt_clr)
        cnt_reg <= match ? CNT_W'(1) : '0;
      else if (match && cnt_reg != CNT_MAX)
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomized and directed bench for seq_detect_param against a list-based reference model.
// Uses a 2-bit counter so saturation is reached quickly.
module tb_seq_detect_param;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             din;
  logic             din_vld;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             mealy_flag;
  logic             moore_flag;
  logic [CNT_W-1:0] match_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: received valid bits, oldest first
  bit         m_bits[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_cnt;

  seq_detect_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .mealy_flag(mealy_flag), .moore_flag(moore_flag),
    .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int clamp_len(input logic [3:0] l);
    if (l == 0) return 1;
    if (l > PAT_W) return PAT_W;
    return int'(l);
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_pat = '0;
    m_len = PAT_W;
    m_ovl = 1'b1;
    m_cnt = 0;
  endtask

  // One clock cycle: called at a negedge, returns at the next negedge.
  task automatic step(input bit d, input bit v, input bit ld, input logic [7:0] p,
                      input logic [3:0] l, input bit o, input bit c);
    bit cand[$];
    bit exp_m;
    din = d; din_vld = v; cfg_load = ld; cfg_pattern = p;
    cfg_len = l; cfg_overlap = o; cnt_clr = c;
    #1;
    exp_m = 1'b0;
    if (v && !ld && (m_bits.size() + 1 >= m_len)) begin
      cand = m_bits;
      cand.push_back(d);
      exp_m = 1'b1;
      for (int i = 0; i < m_len; i++)
        if (cand[cand.size() - 1 - i] != m_pat[i]) exp_m = 1'b0;
    end
    check("mealy", {31'd0, mealy_flag}, {31'd0, exp_m});
    if (ld) begin
      m_pat = p; m_len = clamp_len(l); m_ovl = o; m_bits.delete();
    end else if (v) begin
      if (exp_m && !m_ovl) m_bits.delete();
      else begin
        m_bits.push_back(d);
        if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      end
    end
    if (c) m_cnt = exp_m ? 1 : 0;
    else if (exp_m && m_cnt < CMAX) m_cnt++;
    @(posedge clk);
    #1;
    check("moore", {31'd0, moore_flag}, {31'd0, exp_m});
    check("cnt", 32'(match_cnt), 32'(m_cnt));
    @(negedge clk);
  endtask

  task automatic send(input bit d);
    step(d, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
    step($urandom_range(0, 1), 1'b1, 1'b1, p, l, o, 1'b1);
  endtask

  initial begin
    bit s1[7] = '{1, 0, 1, 1, 0, 1, 1};
    bit s2[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    rst = 1'b1; din = 0; din_vld = 0; cfg_load = 0; cfg_pattern = '0;
    cfg_len = '0; cfg_overlap = 0; cnt_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_mealy", {31'd0, mealy_flag}, 32'd0);
    check("rst_moore", {31'd0, moore_flag}, 32'd0);
    check("rst_cnt", 32'(match_cnt), 32'd0);
    rst = 1'b0;

    // default shadow config: pattern 0, length PAT_W
    for (int i = 0; i < 9; i++) send(1'b0);

    // overlapping 1011
    load(8'b1011, 4'd4, 1'b1);
    foreach (s1[i]) send(s1[i]);
    check("ovl_total", 32'(match_cnt), 32'd2);

    // non-overlapping 1011
    load(8'b1011, 4'd4, 1'b0);
    foreach (s1[i]) send(s1[i]);
    check("novl_total", 32'(match_cnt), 32'd1);

    // valid gaps with toggling din
    load(8'b1011, 4'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send(s1[i]);
      for (int k = 0; k < 3; k++) step(k[0], 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    end

    // length 0 clamps to 1
    load(8'h01, 4'd0, 1'b1);
    for (int i = 0; i < 8; i++) send($urandom_range(0, 1));

    // length 15 clamps to 8
    load(8'hA5, 4'd15, 1'b1);
    foreach (s2[i]) send(s2[i]);
    // reload mid-stream discards that cycle's bit
    for (int i = 0; i < 4; i++) send(s2[i]);
    step(1'b1, 1'b1, 1'b1, 8'hA5, 4'd8, 1'b1, 1'b0);
    for (int i = 4; i < 8; i++) send(s2[i]);

    // saturation and clear
    load(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) send(1'b1);
    check("sat", 32'(match_cnt), 32'd3);
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    check("clr_match", 32'(match_cnt), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    check("clr_only", 32'(match_cnt), 32'd0);

    // async reset right after a match
    load(8'b1011, 4'd4, 1'b1);
    send(1); send(0); send(1); send(1);
    din = 1; din_vld = 1;
    #1 rst = 1'b1;
    #1;
    check("arst_moore", {31'd0, moore_flag}, 32'd0);
    check("arst_cnt", 32'(match_cnt), 32'd0);
    check("arst_mealy", {31'd0, mealy_flag}, 32'd0);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    load(8'b1011, 4'd4, 1'b1);
    send(1); send(0); send(1);
    din = 1; din_vld = 1;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    send(1);
    // reset shadow: 8 zeros in a row required
    for (int i = 0; i < 8; i++) send(1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit ld;
      ld = ($urandom_range(0, 99) < 3);
      step($urandom_range(0, 1), ($urandom_range(0, 3) != 0), ld,
           8'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4)),
           $urandom_range(0, 1), ($urandom_range(0, 99) < 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial sequence detector, the successor to the fixed-pattern mealy/moore detector pair. It accepts a runtime-loadable pattern of 1..PAT_W bits and a selectable overlap mode. Both a Mealy-style (same-cycle) and a Moore-style (registered) match flag come from the same history logic, and a saturating match counter is included. It sits on a serial bit stream qualified by a valid strobe and feeds a status/interrupt path.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of the pattern-length config input; must hold PAT_W
CNT_W, 16, width of the match counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
din  input  1  serial data bit
din_vld  input  1  din is valid this cycle
cfg_load  input  1  latch cfg_pattern/cfg_len/cfg_overlap and clear history
cfg_pattern  input  PAT_W  pattern; low L bits used, cfg_pattern[L-1] is the first bit received, cfg_pattern[0] the last
cfg_len  input  LEN_W  pattern length L
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after a match
cnt_clr  input  1  synchronous clear of match_cnt
mealy_flag  output  1  combinational match, same cycle as the completing bit
moore_flag  output  1  registered match, one cycle after the completing bit
match_cnt  output  CNT_W  saturating count of matches

Behaviour:
- Reset (async, rst=1):
  - hist=0, fill=0, moore_flag=0, match_cnt=0.
  - Shadow config: pattern=0, len=PAT_W, overlap=1.
  - mealy_flag=0 while rst is high.
- Shadow config:
  - Registered only on cfg_load. Detection always uses the shadow values, never the live cfg_* inputs.
  - Effective length: L = clamp(cfg_len, 1, PAT_W). 0 maps to 1; values >PAT_W map to PAT_W.
- History:
  - hist is a PAT_W-bit shift register with the newest bit at the LSB.
  - fill counts valid bits since the last clear and saturates at PAT_W.
  - cand = {hist[PAT_W-2:0], din}.
- Match condition: match = din_vld & ~cfg_load & (fill+1 >= L) & ((cand ^ pattern) & mask == 0), where mask has the low L bits set.
- mealy_flag = match (purely combinational from the inputs and current state).
- moore_flag:
  - Next-state is match. High for exactly one cycle per match, one cycle after the completing bit.
  - Cleared on the cycle after cfg_load.
- Cycle with din_vld=1, no cfg_load:
  - No match, or match with overlap=1: hist<=cand, fill<=min(fill+1, PAT_W).
  - Match with overlap=0: hist<=0, fill<=0. The completing bit cannot start the next match.
- Cycle with din_vld=0: hist, fill and counter hold. Gaps in the valid strobe are transparent.
- cfg_load=1:
  - Shadow config is updated.
  - hist<=0, fill<=0.
  - din that cycle is discarded, with no match.
  - match_cnt is not affected.
- match_cnt:
  - Increments by 1 on each match and saturates at 2^CNT_W-1.
  - cnt_clr alone: count becomes 0.
  - cnt_clr and match in the same cycle: count becomes 1.
- Reset mid-stream: partial history is lost. Detection restarts from fill=0 after rst deasserts.
- No state machine beyond hist/fill. The whole design is a shift-register detector, with L and the overlap mode set at runtime.

Test Plan:
- Overlap: load pattern=4'b1011, L=4, overlap=1. Send din 1,0,1,1,0,1,1 with vld=1 continuously. mealy_flag is high on bits 4 and 7. moore_flag is high the cycle after each. match_cnt=2.
- Non-overlap: same stream with overlap=0. Match on bit 4 only. match_cnt=1.
- Valid gaps: the same 1,0,1,1 bits separated by 3 idle cycles each (vld=0). There is exactly one match, on the final valid bit. din toggling during idle cycles has no effect.
- Length clamp and reload: cfg_len=0 with pattern bit0=1. Every valid 1 matches. Then cfg_len=15 (PAT_W=8) with pattern=8'hA5. Send 1,0,1,0,0,1,0,1. Match on bit 8 only. Loading mid-stream discards that cycle's din.
- Saturation and clear, with CNT_W=2: five matches give match_cnt=3. cnt_clr coincident with a match gives 1. cnt_clr alone gives 0.
- Async reset: send 1,0,1 of 1011, pulse rst between clock edges, then send 1. No match. Outputs read 0 immediately on rst assertion. Shadow len=PAT_W after reset.
